midi_note_frontend: RTL and testbench
=====================================

MIDI_NOTE_FRONTEND -- requirements
Module: midi_note_frontend

Interface
REQ-001 Parameter CHANNEL, default 0, MIDI channel (0-15) this block responds to.
REQ-002 Parameter BAUD_DIV, default 1600, clocks per MIDI bit (50 MHz / 31250 baud).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Rst_p  input  1  reset, asynchronous and active-high.
REQ-005 MIDI_in  input  1  asynchronous serial MIDI line, idle high.
REQ-006 MIDI_data  output  24  last complete message {status, data1, data2}.
REQ-007 RxDne  output  1  one-cycle pulse when a byte is received with a valid stop bit.
REQ-008 State  output  1  receiver busy: high from start-bit detect until the end of the stop bit.
REQ-009 RegOut  output  16  held note register {0, note[6:0], 0, velocity[6:0]}; 0 = silent.
REQ-010 Pitch  output  24  half-period of the held note in Clk cycles; 0 when silent.
REQ-011 Vel  output  8  held velocity, zero-extended; 0 when silent.

Function
REQ-012 MIDI_in SHALL pass through a two-flop synchronizer before any use.
REQ-013 Receiver states IDLE -> START -> DATA -> STOP -> IDLE; IDLE leaves on a synchronized falling edge.
REQ-014 Bits SHALL be sampled at BAUD_DIV/2 into each bit period; if START samples high, return to IDLE without a byte.
REQ-015 Data SHALL be 8 bits, LSB first; STOP sampling 1 pulses RxDne and delivers the byte; STOP sampling 0 discards the byte.
REQ-016 Byte 0xF8-0xFF SHALL be ignored entirely, with no effect on message assembly.
REQ-017 Byte 0xF0-0xF7 SHALL clear the running status and be ignored.
REQ-018 Byte 0x80-0xEF SHALL store the running status and expect data1 next.
REQ-019 A data byte (bit7 = 0) SHALL fill data1, then data2.
REQ-020 When data2 is filled, MIDI_data SHALL update, and a one-cycle internal message strobe SHALL fire in the same cycle.
REQ-021 After a complete message, further data bytes SHALL start a new message under the running status.
REQ-022 Data bytes arriving with no running status SHALL be ignored.
REQ-023 On strobe, Note On (0x9n) with n = CHANNEL and velocity > 0 SHALL load RegOut on the next cycle; a new note replaces the held note.
REQ-024 On strobe, Note Off (0x8n), or Note On with velocity 0, with n = CHANNEL and note equal to the held note SHALL clear RegOut to 0.
REQ-025 A Note Off for a different note, other channels and other message types SHALL leave RegOut unchanged.
REQ-026 If load and clear coincide in the same cycle, clear SHALL win.
REQ-027 Pitch and Vel SHALL be registered and SHALL follow RegOut one cycle later (2 cycles after the strobe).
REQ-028 Pitch SHALL equal BASE[note mod 12] >> (note div 12), truncating.
REQ-029 BASE[k] SHALL be round(25,000,000 / f(k)) with f(k) = 440 * 2^((k-69)/12): a 12-entry constant table, e.g. BASE[0] = 3,057,805 and BASE[9] = 1,818,182.
REQ-030 When RegOut = 0, Pitch and Vel SHALL be 0.
REQ-031 The receiver SHALL continue independently of message decoding; a byte arriving while RegOut updates SHALL not be lost.

Reset
REQ-032 While Rst_p is high: synchronizer flops = 1, receiver in IDLE, State = 0, RxDne = 0, running status cleared, MIDI_data = 0, RegOut = 0, Pitch = 0, Vel = 0.
REQ-033 Reset mid-byte SHALL abort the byte without asserting RxDne; after release, the next falling edge starts a fresh byte.

Verification
REQ-034 Send 0x90,0x45,0x64 (CHANNEL = 0) -> three RxDne pulses; MIDI_data = 0x904564; RegOut = 0x4564; Pitch = 56,818; Vel = 100.
REQ-035 Then send 0x80,0x40,0x00 -> RegOut unchanged (note mismatch); then 0x80,0x45,0x00 -> RegOut = 0, Pitch = 0, Vel = 0.
REQ-036 Send 0x90,0x3C,0x7F, then running-status 0x3C,0x00 -> Pitch = 95,556 after the first message; then cleared to 0 by the velocity-0 message.
REQ-037 Send 0x91,0x45,0x64 with CHANNEL = 0 -> MIDI_data = 0x914564, RegOut stays 0.
REQ-038 Send 0x90,0xF8,0x45,0x64 (real-time byte inserted) -> note loaded exactly as in REQ-034.
REQ-039 Byte with stop bit driven 0 -> no RxDne and no state change; assert Rst_p mid-byte -> all outputs 0, and the next clean message decodes correctly.

Source files
------------

// File: rtl/midi_note_frontend_if.sv
// midi_note_frontend_if: serial MIDI line in; decoded message and held-note outputs
//   midi_in   : async serial MIDI line, idle high
//   midi_data : last complete {status, data1, data2}
//   rx_dne    : one-cycle pulse per byte received with a valid stop bit
//   state     : receiver busy
//   reg_out   : held note {0, note, 0, velocity}, 0 = silent
//   pitch     : half-period of the held note in clk cycles
//   vel       : held velocity, zero-extended
interface midi_note_frontend_if;
   logic        midi_in;
   logic [23:0] midi_data;
   logic        rx_dne;
   logic        state;
   logic [15:0] reg_out;
   logic [23:0] pitch;
   logic [7:0]  vel;
   modport master (output midi_in, input midi_data, rx_dne, state, reg_out, pitch, vel);
   modport slave (input midi_in, output midi_data, rx_dne, state, reg_out, pitch, vel);
endinterface

// File: rtl/midi_note_frontend.sv
// midi_note_frontend: MIDI UART receiver, running-status message assembly and note/pitch decode
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : midi_note_frontend_if.slave (midi_in in; midi_data, rx_dne, state, reg_out, pitch, vel out)
module midi_note_frontend #(
   parameter int CHANNEL  = 0,
   parameter int BAUD_DIV = 1600
) (
   input logic                 clk,
   input logic                 rst,
   midi_note_frontend_if.slave bus
);
   localparam int CW = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [3:0] CH = 4'(CHANNEL);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   logic [1:0] sync_q;
   logic rx_prev_q;
   rx_state_t st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic stop_ok_q, stop_ok_d;
   logic dne_q, dne_d;
   logic [7:0] status_q, status_d, d1_q, d1_d;
   logic have_d1_q, have_d1_d;
   logic strobe_q, strobe_d;
   logic [23:0] data_q, data_d;
   logic [15:0] reg_q, reg_d;
   logic [23:0] pitch_q, pitch_d;
   logic [7:0] vel_q, vel_d;
   logic rx, fall;
   logic [6:0] note, held;
   logic ch_ok, is_on, is_off, vel_zero, load, clear;
   logic [3:0] oct, key;
   logic [21:0] base;
   assign rx   = sync_q[1];
   assign fall = rx_prev_q & ~rx;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
         st_q      <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         stop_ok_q <= 1'b0;
         dne_q     <= 1'b0;
         status_q  <= '0;
         d1_q      <= '0;
         have_d1_q <= 1'b0;
         strobe_q  <= 1'b0;
         data_q    <= '0;
         reg_q     <= '0;
         pitch_q   <= '0;
         vel_q     <= '0;
      end else begin
         sync_q    <= {sync_q[0], bus.midi_in};
         rx_prev_q <= rx;
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         stop_ok_q <= stop_ok_d;
         dne_q     <= dne_d;
         status_q  <= status_d;
         d1_q      <= d1_d;
         have_d1_q <= have_d1_d;
         strobe_q  <= strobe_d;
         data_q    <= data_d;
         reg_q     <= reg_d;
         pitch_q   <= pitch_d;
         vel_q     <= vel_d;
      end
   end
   // Receiver: START samples mid-bit, then every full bit period lands mid-bit.
   // After a good stop sample we stay busy for the rest of the stop bit, but a
   // new falling edge there is taken straight away as the next start bit.
   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q + CW'(1);
      bit_d     = bit_q;
      sh_d      = sh_q;
      stop_ok_d = stop_ok_q;
      dne_d     = 1'b0;
      case (st_q)
         IDLE: begin
            cnt_d     = '0;
            stop_ok_d = 1'b0;
            st_d      = fall ? START : IDLE;
         end
         START: if (cnt_q == HALF) begin
            cnt_d = '0;
            bit_d = '0;
            st_d  = rx ? IDLE : DATA;
         end
         DATA: if (cnt_q == FULL) begin
            cnt_d = '0;
            sh_d  = {rx, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            st_d  = (bit_q == 3'd7) ? STOP : DATA;
         end
         STOP: if (stop_ok_q) begin
            if (fall) begin
               st_d      = START;
               cnt_d     = '0;
               stop_ok_d = 1'b0;
            end else if (cnt_q == HALF) begin
               st_d      = IDLE;
               stop_ok_d = 1'b0;
            end
         end else if (cnt_q == FULL) begin
            cnt_d     = '0;
            stop_ok_d = rx;
            dne_d     = rx;
            st_d      = rx ? STOP : IDLE;
         end
         default: st_d = IDLE;
      endcase
   end
   // Message assembly with running status; real-time bytes pass through untouched.
   always_comb begin
      status_d  = status_q;
      d1_d      = d1_q;
      have_d1_d = have_d1_q;
      strobe_d  = 1'b0;
      data_d    = data_q;
      if (dne_q) begin
         if (sh_q[7:3] == 5'b11110) begin
            status_d  = '0;
            have_d1_d = 1'b0;
         end else if (sh_q[7:4] != 4'hF && sh_q[7]) begin
            status_d  = sh_q;
            have_d1_d = 1'b0;
         end else if (!sh_q[7] && status_q[7]) begin
            d1_d      = have_d1_q ? d1_q : sh_q;
            have_d1_d = !have_d1_q;
            strobe_d  = have_d1_q;
            data_d    = have_d1_q ? {status_q, d1_q, sh_q} : data_q;
         end
      end
   end
   assign note     = data_q[14:8];
   assign held     = reg_q[14:8];
   assign ch_ok    = data_q[19:16] == CH;
   assign is_on    = data_q[23:20] == 4'h9;
   assign is_off   = data_q[23:20] == 4'h8;
   assign vel_zero = ~|data_q[6:0];
   assign load     = strobe_q & ch_ok & is_on & ~vel_zero;
   assign clear    = strobe_q & ch_ok & (is_off | (is_on & vel_zero)) & (note == held);
   assign reg_d    = clear ? '0 : load ? {1'b0, note, 1'b0, data_q[6:0]} : reg_q;
   assign oct      = 4'(held / 7'd12);
   assign key      = 4'(held % 7'd12);
   // Half-periods of octave 0 (notes 0..11) at 50 MHz; higher octaves halve per octave.
   always_comb begin
      base = 22'd0;
      case (key)
         4'd0:  base = 22'd3057805;
         4'd1:  base = 22'd2886184;
         4'd2:  base = 22'd2724195;
         4'd3:  base = 22'd2571297;
         4'd4:  base = 22'd2426982;
         4'd5:  base = 22'd2290766;
         4'd6:  base = 22'd2162195;
         4'd7:  base = 22'd2040840;
         4'd8:  base = 22'd1926297;
         4'd9:  base = 22'd1818182;
         4'd10: base = 22'd1716135;
         4'd11: base = 22'd1619816;
         default: base = 22'd0;
      endcase
   end
   assign pitch_d = |reg_q ? {2'b00, base} >> oct : '0;
   assign vel_d   = |reg_q ? {1'b0, reg_q[6:0]} : '0;
   assign bus.midi_data = data_q;
   assign bus.rx_dne    = dne_q;
   assign bus.state     = st_q != IDLE;
   assign bus.reg_out   = reg_q;
   assign bus.pitch     = pitch_q;
   assign bus.vel       = vel_q;
endmodule

// File: tb/tb_midi_note_frontend.sv
// tb_midi_note_frontend: directed self-checking bench for midi_note_frontend
module tb_midi_note_frontend;
   localparam int BAUD = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   int dne_cnt = 0;
   int d0;
   midi_note_frontend_if bus ();
   midi_note_frontend #(.CHANNEL(0), .BAUD_DIV(BAUD)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.rx_dne) dne_cnt <= dne_cnt + 1;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, act, act, exp, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, input logic stop);
      bus.midi_in = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.midi_in = b[i];
         repeat (BAUD) @(negedge clk);
      end
      bus.midi_in = stop;
      repeat (BAUD) @(negedge clk);
      bus.midi_in = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
   endtask
   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_byte(a, 1'b1);
      send_byte(b, 1'b1);
      send_byte(c, 1'b1);
   endtask
   task automatic check_silent(input string tag);
      check({tag, " reg"}, bus.reg_out, 0);
      check({tag, " pitch"}, bus.pitch, 0);
      check({tag, " vel"}, bus.vel, 0);
   endtask
   initial begin
      bus.midi_in = 1'b1;
      repeat (4) @(negedge clk);
      check("rst midi_data", bus.midi_data, 0);
      check("rst rx_dne", bus.rx_dne, 0);
      check("rst state", bus.state, 0);
      check_silent("rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      d0 = dne_cnt;
      send3(8'h90, 8'h45, 8'h64);
      check("on dne count", dne_cnt - d0, 3);
      check("on midi_data", bus.midi_data, 32'h904564);
      check("on reg", bus.reg_out, 32'h4564);
      check("on pitch", bus.pitch, 56818);
      check("on vel", bus.vel, 100);
      send3(8'h80, 8'h40, 8'h00);
      check("off other midi_data", bus.midi_data, 32'h804000);
      check("off other reg", bus.reg_out, 32'h4564);
      send3(8'h80, 8'h45, 8'h00);
      check_silent("off match");
      send3(8'h90, 8'h3C, 8'h7F);
      check("c4 reg", bus.reg_out, 32'h3C7F);
      check("c4 pitch", bus.pitch, 95556);
      check("c4 vel", bus.vel, 127);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h00, 1'b1);
      check("running midi_data", bus.midi_data, 32'h903C00);
      check_silent("running vel0");
      send3(8'h91, 8'h45, 8'h64);
      check("ch1 midi_data", bus.midi_data, 32'h914564);
      check("ch1 reg", bus.reg_out, 0);
      d0 = dne_cnt;
      send_byte(8'h90, 1'b1);
      send3(8'hF8, 8'h45, 8'h64);
      check("rt dne count", dne_cnt - d0, 4);
      check("rt midi_data", bus.midi_data, 32'h904564);
      check("rt reg", bus.reg_out, 32'h4564);
      check("rt pitch", bus.pitch, 56818);
      check("rt vel", bus.vel, 100);
      send3(8'hF0, 8'h45, 8'h00);
      check("sysex midi_data", bus.midi_data, 32'h904564);
      check("sysex reg", bus.reg_out, 32'h4564);
      d0 = dne_cnt;
      send_byte(8'h80, 1'b0);
      check("badstop dne count", dne_cnt - d0, 0);
      send_byte(8'h45, 1'b1);
      send_byte(8'h00, 1'b1);
      check("badstop midi_data", bus.midi_data, 32'h904564);
      check("badstop reg", bus.reg_out, 32'h4564);
      bus.midi_in = 1'b0;
      repeat (3 * BAUD) @(negedge clk);
      check("midbyte busy", bus.state, 1);
      d0 = dne_cnt;
      rst = 1'b1;
      bus.midi_in = 1'b1;
      @(negedge clk);
      check("midrst midi_data", bus.midi_data, 0);
      check("midrst state", bus.state, 0);
      check("midrst rx_dne", bus.rx_dne, 0);
      check_silent("midrst");
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (12 * BAUD) @(negedge clk);
      check("midrst no dne", dne_cnt - d0, 0);
      send3(8'h90, 8'h45, 8'h64);
      check("post rst midi_data", bus.midi_data, 32'h904564);
      check("post rst reg", bus.reg_out, 32'h4564);
      check("post rst pitch", bus.pitch, 56818);
      send3(8'h90, 8'h7F, 8'h01);
      check("n127 reg", bus.reg_out, 32'h7F01);
      check("n127 pitch", bus.pitch, 1993);
      check("n127 vel", bus.vel, 1);
      send3(8'h90, 8'h00, 8'h40);
      check("n0 reg", bus.reg_out, 32'h0040);
      check("n0 pitch", bus.pitch, 3057805);
      check("n0 vel", bus.vel, 64);
      send3(8'h80, 8'h00, 8'h00);
      check_silent("n0 off");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
